branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 102 ++++++++++
 tb/tb_branch_target_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
// Lookup is combinational against the registered table; updates land on the next rising edge.
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        predictedTaken,
    output logic [31:0] predicted_target,
    input  logic        update_btb,
    input  logic [31:0] update_pc,
    input  logic        jump_en,
    input  logic [31:0] calc_jump_addr,
    input  logic        pipeline_flush
);

    localparam int TAG_W = 32 - 2 - IDX_W;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    ctr_e             r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_fetch_idx;
    logic [TAG_W-1:0] w_fetch_tag;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_fetch_hit;
    logic             w_upd_hit;
    logic             w_unused;

    assign w_fetch_idx = fetch_pc[IDX_W+1:2];
    assign w_fetch_tag = fetch_pc[31:IDX_W+2];
    assign w_upd_idx   = update_pc[IDX_W+1:2];
    assign w_upd_tag   = update_pc[31:IDX_W+2];

    // pipeline_flush and the byte-offset bits have no effect on the table.
    assign w_unused = ^{pipeline_flush, fetch_pc[1:0], update_pc[1:0]};

    function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
        ctr_e nxt;
        case (cur)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = CTR_WNT;
        endcase
        return nxt;
    endfunction

    // Lookup and hit detection for both the fetch and the update ports.
    always_comb begin
        w_fetch_hit      = 1'b0;
        w_upd_hit        = 1'b0;
        predictedTaken   = 1'b0;
        predicted_target = fetch_pc + 32'd4;
        w_fetch_hit = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
        w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
        if (w_fetch_hit && r_ctr[w_fetch_idx][1]) begin
            predictedTaken   = 1'b1;
            predicted_target = r_target[w_fetch_idx];
        end else begin
            predictedTaken   = 1'b0;
            predicted_target = fetch_pc + 32'd4;
        end
    end

    // Table state: reset wins; otherwise at most the single entry at update_pc changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'd0;
                r_ctr[i]    <= CTR_WNT;
            end
        end else if (update_btb) begin
            if (w_upd_hit) begin
                r_ctr[w_upd_idx] <= ctr_next(r_ctr[w_upd_idx], jump_en);
                if (jump_en) begin
                    r_target[w_upd_idx] <= calc_jump_addr;
                end
            end else if (jump_en) begin
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= calc_jump_addr;
                r_ctr[w_upd_idx]    <= CTR_WT;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer; expected values are hand-computed.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fetch_pc = 32'd0;
    logic        predictedTaken;
    logic [31:0] predicted_target;
    logic        update_btb = 1'b0;
    logic [31:0] update_pc = 32'd0;
    logic        jump_en = 1'b0;
    logic [31:0] calc_jump_addr = 32'd0;
    logic        pipeline_flush = 1'b0;

    int errors = 0;
    int checks = 0;

    branch_target_buffer #(.ENTRIES(16), .IDX_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .predictedTaken   (predictedTaken),
        .predicted_target (predicted_target),
        .update_btb       (update_btb),
        .update_pc        (update_pc),
        .jump_en          (jump_en),
        .calc_jump_addr   (calc_jump_addr),
        .pipeline_flush   (pipeline_flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        update_btb     = 1'b1;
        update_pc      = pc;
        jump_en        = taken;
        calc_jump_addr = tgt;
        tick();
        update_btb = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        fetch_pc = pc;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        lookup(32'h100);
        checks++;
        if (predictedTaken !== 1'b0 || predicted_target !== 32'h104) begin
            errors++;
            $display("FAIL reset_0x100: taken=%0b target=%h required taken=0 target=00000104", predictedTaken, predicted_target);
        end
        lookup(32'hFFFF_FFFC);
        checks++;
        if (predictedTaken !== 1'b0 || predicted_target !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_wrap: taken=%0b target=%h required taken=0 target=00000000", predictedTaken, predicted_target);
        end
        lookup(32'h1234_5672);
        checks++;
        if (predictedTaken !== 1'b0 || predicted_target !== 32'h1234_5676) begin
            errors++;
            $display("FAIL reset_unaligned: taken=%0b target=%h required taken=0 target=12345676", predictedTaken, predicted_target);
        end
    endtask

    task automatic test_allocate();
        do_update(32'h100, 1'b1, 32'h200);
        lookup(32'h100);
        checks++;
        if (predictedTaken !== 1'b1 || predicted_target !== 32'h200) begin
            errors++;
            $display("FAIL alloc_hit: taken=%0b target=%h required taken=1 target=00000200", predictedTaken, predicted_target);
        end
        lookup(32'h102);
        checks++;
        if (predictedTaken !== 1'b1 || predicted_target !== 32'h200) begin
            errors++;
            $display("FAIL alloc_offset_ignored: taken=%0b target=%h required taken=1 target=00000200", predictedTaken, predicted_target);
        end
        lookup(32'h104);
        checks++;
        if (predictedTaken !== 1'b0 || predicted_target !== 32'h108) begin
            errors++;
            $display("FAIL alloc_other_idx: taken=%0b target=%h required taken=0 target=00000108", predictedTaken, predicted_target);
        end
    endtask

    // Entry at 0x100 starts at WT (10) with target 0x200.
    task automatic test_counter();
        do_update(32'h100, 1'b0, 32'hDEAD_0000);
        lookup(32'h100);
        checks++;
        if (predictedTaken !== 1'b0 || predicted_target !== 32'h104) begin
            errors++;
            $display("FAIL ctr_10_to_01: taken=%0b target=%h required taken=0 target=00000104", predictedTaken, predicted_target);
        end
        do_update(32'h100, 1'b0, 32'hDEAD_0000);
        do_update(32'h100, 1'b0, 32'hDEAD_0000);
        do_update(32'h100, 1'b1, 32'h240);
        lookup(32'h100);
        checks++;
        if (predictedTaken !== 1'b0 || predicted_target !== 32'h104) begin
            errors++;
            $display("FAIL ctr_sat_00_then_01: taken=%0b target=%h required taken=0 target=00000104", predictedTaken, predicted_target);
        end
        do_update(32'h100, 1'b1, 32'h240);
        lookup(32'h100);
        checks++;
        if (predictedTaken !== 1'b1 || predicted_target !== 32'h240) begin
            errors++;
            $display("FAIL ctr_01_to_10: taken=%0b target=%h required taken=1 target=00000240", predictedTaken, predicted_target);
        end
        do_update(32'h100, 1'b1, 32'h280);
        do_update(32'h100, 1'b1, 32'h280);
        do_update(32'h100, 1'b0, 32'hDEAD_0000);
        lookup(32'h100);
        checks++;
        if (predictedTaken !== 1'b1 || predicted_target !== 32'h280) begin
            errors++;
            $display("FAIL ctr_sat_11_then_10: taken=%0b target=%h required taken=1 target=00000280", predictedTaken, predicted_target);
        end
    endtask

    task automatic test_x_idle();
        update_btb     = 1'b0;
        update_pc      = 32'hxxxx_xxxx;
        jump_en        = 1'bx;
        calc_jump_addr = 32'hxxxx_xxxx;
        pipeline_flush = 1'b1;
        repeat (3) tick();
        pipeline_flush = 1'b0;
        lookup(32'h100);
        checks++;
        if (predictedTaken !== 1'b1 || predicted_target !== 32'h280) begin
            errors++;
            $display("FAIL idle_x_no_change: taken=%0b target=%h required taken=1 target=00000280", predictedTaken, predicted_target);
        end
    endtask

    task automatic test_alias();
        apply_reset();
        do_update(32'h100, 1'b1, 32'h200);
        do_update(32'h140, 1'b1, 32'h300);
        lookup(32'h100);
        checks++;
        if (predictedTaken !== 1'b0 || predicted_target !== 32'h104) begin
            errors++;
            $display("FAIL alias_old_miss: taken=%0b target=%h required taken=0 target=00000104", predictedTaken, predicted_target);
        end
        lookup(32'h140);
        checks++;
        if (predictedTaken !== 1'b1 || predicted_target !== 32'h300) begin
            errors++;
            $display("FAIL alias_new_hit: taken=%0b target=%h required taken=1 target=00000300", predictedTaken, predicted_target);
        end
        do_update(32'h180, 1'b0, 32'h999);
        lookup(32'h140);
        checks++;
        if (predictedTaken !== 1'b1 || predicted_target !== 32'h300) begin
            errors++;
            $display("FAIL alias_nt_miss_no_change: taken=%0b target=%h required taken=1 target=00000300", predictedTaken, predicted_target);
        end
        lookup(32'h180);
        checks++;
        if (predictedTaken !== 1'b0 || predicted_target !== 32'h184) begin
            errors++;
            $display("FAIL alias_nt_no_alloc: taken=%0b target=%h required taken=0 target=00000184", predictedTaken, predicted_target);
        end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        fetch_pc       = 32'h100;
        update_btb     = 1'b1;
        update_pc      = 32'h100;
        jump_en        = 1'b1;
        calc_jump_addr = 32'h200;
        #1;
        checks++;
        if (predictedTaken !== 1'b0 || predicted_target !== 32'h104) begin
            errors++;
            $display("FAIL same_cycle_pre: taken=%0b target=%h required taken=0 target=00000104", predictedTaken, predicted_target);
        end
        tick();
        update_btb = 1'b0;
        #1;
        checks++;
        if (predictedTaken !== 1'b1 || predicted_target !== 32'h200) begin
            errors++;
            $display("FAIL same_cycle_post: taken=%0b target=%h required taken=1 target=00000200", predictedTaken, predicted_target);
        end
    endtask

    task automatic test_reset_priority();
        do_update(32'h140, 1'b1, 32'h300);
        rst            = 1'b1;
        update_btb     = 1'b1;
        update_pc      = 32'h100;
        jump_en        = 1'b1;
        calc_jump_addr = 32'h200;
        tick();
        rst        = 1'b0;
        update_btb = 1'b0;
        lookup(32'h100);
        checks++;
        if (predictedTaken !== 1'b0 || predicted_target !== 32'h104) begin
            errors++;
            $display("FAIL rst_prio_dropped: taken=%0b target=%h required taken=0 target=00000104", predictedTaken, predicted_target);
        end
        lookup(32'h140);
        checks++;
        if (predictedTaken !== 1'b0 || predicted_target !== 32'h144) begin
            errors++;
            $display("FAIL rst_mid_history_gone: taken=%0b target=%h required taken=0 target=00000144", predictedTaken, predicted_target);
        end
        // A post-reset allocation must start at WT with fresh state.
        do_update(32'h100, 1'b1, 32'h220);
        lookup(32'h100);
        checks++;
        if (predictedTaken !== 1'b1 || predicted_target !== 32'h220) begin
            errors++;
            $display("FAIL rst_then_alloc: taken=%0b target=%h required taken=1 target=00000220", predictedTaken, predicted_target);
        end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_counter();
        test_x_idle();
        test_alias();
        test_same_cycle();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
